// File: rtl/bcd_seq.sv
// bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
// A 20-bit unsigned value is converted into six packed BCD digits over 20
// iterations, one iteration per clock. The registered result feeds the
// six-digit decimal display and is held stable between conversions.
//
// Ports:
//   iCLK     system clock, rising edge
//   iRST     asynchronous active-high reset
//   iStart   conversion request, sampled only while idle
//   iBin     20-bit unsigned value, captured on the accepting edge
//   oBusy    high while a conversion is in flight (SHIFT and FIN)
//   oDone    one-cycle pulse, new result valid on oBcd in this cycle
//   oBcd     packed BCD result, digit k in [4k+3:4k], held until next oDone
//   oOvf     input exceeded 999999 and the result was saturated
//   oDigits  number of significant digits (1..6), held with oBcd
module bcd_seq (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [19:0] iBin,
  output logic        oBusy,
  output logic        oDone,
  output logic [23:0] oBcd,
  output logic        oOvf,
  output logic [2:0]  oDigits
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  localparam logic [19:0] MAX_DEC = 20'd999999;
  localparam logic [23:0] SAT_BCD = 24'h999999;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [19:0] binSr;
  logic [23:0] scratch;
  logic        ovfPending;
  logic [23:0] adjusted;
  logic [23:0] finalBcd;

  // Every nibble >= 5 gets +3 before the shift, all digits in parallel.
  function automatic logic [23:0] addThree(input logic [23:0] bcd);
    logic [23:0] res;
    logic [3:0]  nib;
    res = bcd;
    for (int k = 0; k < 6; k++) begin
      nib = bcd[4*k +: 4];
      if (nib >= 4'd5) begin
        res[4*k +: 4] = nib + 4'd3;
      end
    end
    return res;
  endfunction

  // Saturate to the largest displayable value when the input is out of range.
  function automatic logic [23:0] saturate(input logic [23:0] bcd, input logic ovf);
    return ovf ? SAT_BCD : bcd;
  endfunction

  // 1 + index of the most significant nonzero digit; zero reports one digit.
  function automatic logic [2:0] digitCount(input logic [23:0] bcd);
    logic [2:0] res;
    res = 3'd1;
    for (int k = 0; k < 6; k++) begin
      if (bcd[4*k +: 4] != 4'd0) begin
        res = 3'(k + 1);
      end
    end
    return res;
  endfunction

  assign adjusted = addThree(scratch);
  assign finalBcd = saturate(scratch, ovfPending);
  assign oBusy    = (state != IDLE);

  // Control and output registers
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= IDLE;
      count   <= 5'd0;
      oDone   <= 1'b0;
      oBcd    <= 24'h000000;
      oOvf    <= 1'b0;
      oDigits <= 3'd1;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            count <= 5'd0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          count <= count + 5'd1;
          if (count == 5'd19) begin
            state <= FIN;
          end
        end
        FIN: begin
          oBcd    <= finalBcd;
          oOvf    <= ovfPending;
          oDigits <= digitCount(finalBcd);
          oDone   <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Conversion datapath (no reset: always reloaded on the accepting edge)
  always_ff @(posedge iCLK) begin
    case (state)
      IDLE: begin
        if (iStart) begin
          binSr      <= iBin;
          scratch    <= 24'h000000;
          ovfPending <= (iBin > MAX_DEC);
        end
      end
      SHIFT: begin
        // Carry out of the top digit is dropped; it only happens on overflow,
        // where the result is saturated anyway.
        scratch <= {adjusted[22:0], binSr[19]};
        binSr   <= {binSr[18:0], 1'b0};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_seq.sv
module tb_bcd_seq;

  logic        iCLK;
  logic        iRST;
  logic        iStart;
  logic [19:0] iBin;
  logic        oBusy;
  logic        oDone;
  logic [23:0] oBcd;
  logic        oOvf;
  logic [2:0]  oDigits;

  int checks = 0;
  int errors = 0;

  // Expected results packed as {digits, ovf, bcd}.
  logic [27:0] expQ[$];

  bcd_seq dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iStart  (iStart),
    .iBin    (iBin),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oBcd    (oBcd),
    .oOvf    (oOvf),
    .oDigits (oDigits)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every oDone pops one expected result and compares it.
  always @(negedge iCLK) begin
    logic [27:0] e;
    if (!iRST && oDone) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got oBcd=%06h with no result pending, expected none", oBcd);
      end else begin
        e = expQ.pop_front();
        check("result_bcd", 32'(oBcd), 32'(e[23:0]));
        check("result_ovf", 32'(oOvf), 32'(e[24]));
        check("result_digits", 32'(oDigits), 32'(e[27:25]));
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    check({tag, "_bcd"}, 32'(oBcd), 32'h0);
    check({tag, "_ovf"}, 32'(oOvf), 32'h0);
    check({tag, "_digits"}, 32'(oDigits), 32'd1);
    check({tag, "_busy"}, 32'(oBusy), 32'h0);
    check({tag, "_done"}, 32'(oDone), 32'h0);
  endtask

  // One conversion with a single-cycle start pulse; checks timing and hold.
  task automatic doConv(input logic [19:0] bin, input logic [23:0] expBcd,
                        input logic expOvf, input logic [2:0] expDig);
    int n;
    int busyCnt;
    @(negedge iCLK);
    iBin   = bin;
    iStart = 1'b1;
    expQ.push_back({expDig, expOvf, expBcd});
    @(negedge iCLK);
    // Accept edge has passed; scramble inputs to prove capture-on-accept.
    iStart  = 1'b0;
    iBin    = ~bin;
    n       = 1;
    busyCnt = 0;
    while (!oDone && n < 40) begin
      if (oBusy) busyCnt++;
      if (n == 5) begin
        iStart = 1'b1;          // ignored while busy
      end else begin
        iStart = 1'b0;
      end
      @(negedge iCLK);
      n++;
    end
    iStart = 1'b0;
    check("done_latency", 32'(n), 32'd22);
    check("busy_cycles", 32'(busyCnt), 32'd21);
    check("busy_low_at_done", 32'(oBusy), 32'h0);
    repeat (5) @(negedge iCLK);
    check("hold_bcd", 32'(oBcd), 32'(expBcd));
    check("hold_done_low", 32'(oDone), 32'h0);
  endtask

  initial begin
    int bad;
    iRST   = 1'b1;
    iStart = 1'b0;
    iBin   = 20'd0;
    repeat (3) @(negedge iCLK);
    checkResetOutputs("reset");
    iRST = 1'b0;

    doConv(20'd0,       24'h000000, 1'b0, 3'd1);
    doConv(20'd123456,  24'h123456, 1'b0, 3'd6);
    doConv(20'd40,      24'h000040, 1'b0, 3'd2);
    doConv(20'd999999,  24'h999999, 1'b0, 3'd6);
    doConv(20'd1000000, 24'h999999, 1'b1, 3'd6);
    doConv(20'hFFFFF,   24'h999999, 1'b1, 3'd6);
    doConv(20'd7,       24'h000007, 1'b0, 3'd1);

    // iStart held high, iBin = 1000*j + 7 at negedge j; accepts at j=0,22,44.
    expQ.push_back({3'd1, 1'b0, 24'h000007});
    expQ.push_back({3'd5, 1'b0, 24'h022007});
    expQ.push_back({3'd5, 1'b0, 24'h044007});
    bad = 0;
    for (int j = 0; j <= 66; j++) begin
      @(negedge iCLK);
      if (j >= 1) begin
        checks++;
        if (oDone !== ((j % 22) == 0)) begin
          errors++;
          bad++;
          $display("FAIL held_start_done_at_%0d: got %0b, expected %0b", j, oDone, (j % 22) == 0);
        end
      end
      iBin   = 20'(1000 * j + 7);
      iStart = (j <= 44);
    end
    iStart = 1'b0;
    repeat (3) @(negedge iCLK);
    check("held_start_queue_drained", 32'(expQ.size()), 32'd0);

    // Reset in the middle of a conversion of 654321.
    @(negedge iCLK);
    iBin   = 20'd654321;
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    repeat (9) @(negedge iCLK);   // now between edges E9 and E10
    check("pre_reset_busy", 32'(oBusy), 32'h1);
    iRST = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    bad = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge iCLK);
      if (oDone || oBusy) bad++;
    end
    check("no_done_after_reset", 32'(bad), 32'd0);
    check("outputs_still_reset", 32'(oBcd), 32'h0);

    doConv(20'd5, 24'h000005, 1'b0, 3'd1);
    check("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
